// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// initiator FSM state encoding (also used by the timer's slave wrapper).
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Saturating bus-wait counter; expired stays high until cleared or reset.
module axi_lite_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != LIMIT)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction,
// one response out. The watchdog only flags a stall; it never aborts the bus.
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_write,
   output logic                    timeout,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp
);

   import axi_lite_pkg::*;

   state_t                  state;
   logic                    aw_done, w_done;
   logic                    accept, aw_hs, w_hs, bus_wait;
   logic [ADDR_WIDTH-1:0]   addr_q;

   assign cmd_ready = (state == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign aw_hs     = m_axi_awvalid && m_axi_awready;
   assign w_hs      = m_axi_wvalid && m_axi_wready;
   assign bus_wait  = (state == WR_REQ) || (state == WR_RESP) ||
                      (state == RD_REQ) || (state == RD_RESP);

   // Single-phase handshakes decode straight from the state register
   assign m_axi_arvalid = (state == RD_REQ);
   assign m_axi_bready  = (state == WR_RESP);
   assign m_axi_rready  = (state == RD_RESP);
   assign rsp_valid     = (state == RSP);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awprot  = PROT_DEFAULT;
   assign m_axi_arprot  = PROT_DEFAULT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         addr_q        <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= RESP_OKAY;
         rsp_write     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_addr;
                  m_axi_wdata <= cmd_wdata;
                  m_axi_wstrb <= cmd_wstrb;
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
                  if (cmd_write) begin
                     state         <= WR_REQ;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                  end else begin
                     state <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               // AW and W retire independently; leave once both have, even in one cycle
               if (aw_hs) begin
                  m_axi_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  rsp_resp  <= m_axi_bresp;
                  rsp_rdata <= '0;
                  rsp_write <= 1'b1;
                  state     <= RSP;
               end
            end
            RD_REQ: begin
               if (m_axi_arready) begin
                  state <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_axi_rvalid) begin
                  rsp_rdata <= m_axi_rdata;
                  rsp_resp  <= m_axi_rresp;
                  rsp_write <= 1'b0;
                  state     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axi_lite_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (bus_wait),
      .expired(timeout)
   );

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable-latency slave model
// and a scoreboard of expected responses.
module tb_axi_lite_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write, timeout;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awprot(awprot),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
      .m_axi_wstrb(wstrb),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
      .m_axi_arprot(arprot),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
      .m_axi_rresp(rresp)
   );

   // Slave model: four registers at 0x00..0x0C, anything else answers SLVERR
   int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   int            aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
   logic          s_aw_got, s_w_got, b_pend, r_pend;
   logic [AW-1:0] s_awaddr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_wstrb;
   logic [DW-1:0] mem [4];

   assign awready = awvalid && (aw_wait >= aw_delay);
   assign wready  = wvalid && (w_wait >= w_delay);
   assign arready = arvalid && (ar_wait >= ar_delay);

   always @(posedge clk) begin : slave
      logic          a_ok, d_ok;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      logic [3:0]    st;
      if (reset) begin
         s_aw_got <= 1'b0; s_w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
         rdata <= '0; aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
         s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         a_ok = s_aw_got || (awvalid && awready);
         d_ok = s_w_got || (wvalid && wready);
         ad   = s_aw_got ? s_awaddr : awaddr;
         wd   = s_w_got ? s_wdata : wdata;
         st   = s_w_got ? s_wstrb : wstrb;
         if (awvalid && awready) begin
            aw_wait <= 0; s_aw_got <= 1'b1; s_awaddr <= awaddr;
         end else if (awvalid) aw_wait <= aw_wait + 1;
         if (wvalid && wready) begin
            w_wait <= 0; s_w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
         end else if (wvalid) w_wait <= w_wait + 1;
         if (a_ok && d_ok) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0;
            if (ad < 16) begin
               for (int b = 0; b < 4; b++)
                  if (st[b]) mem[ad[3:2]][8*b +: 8] <= wd[8*b +: 8];
               bresp <= 2'b00;
            end else bresp <= 2'b10;
            if (b_delay == 0) bvalid <= 1'b1;
            else begin b_pend <= 1'b1; b_cnt <= 1; end
         end
         if (b_pend) begin
            if (b_cnt >= b_delay) begin bvalid <= 1'b1; b_pend <= 1'b0; end
            else b_cnt <= b_cnt + 1;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            ar_wait <= 0;
            rdata   <= (araddr < 16) ? mem[araddr[3:2]] : '0;
            rresp   <= (araddr < 16) ? 2'b00 : 2'b10;
            if (r_delay == 0) rvalid <= 1'b1;
            else begin r_pend <= 1'b1; r_cnt <= 1; end
         end else if (arvalid) ar_wait <= ar_wait + 1;
         if (r_pend) begin
            if (r_cnt >= r_delay) begin rvalid <= 1'b1; r_pend <= 1'b0; end
            else r_cnt <= r_cnt + 1;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   typedef struct {
      logic          wr;
      logic [DW-1:0] rd;
      logic [1:0]    resp;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic [DW-1:0] er, input logic [1:0] ersp);
      exp_t e;
      logic acc;
      e.wr = w; e.rd = er; e.resp = ersp;
      sb.push_back(e);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!acc) check("cmd_accept", {63'd0, acc}, 64'd1);
   endtask

   task automatic get_rsp(input int limit, output int lat);
      exp_t e;
      lat = 0;
      while (!rsp_valid && lat < limit) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         check("rsp_bound", {63'd0, rsp_valid}, 64'd1);
      end else if (sb.size() == 0) begin
         check("sb_empty_on_rsp", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check("rsp_write", {63'd0, rsp_write}, {63'd0, e.wr});
         check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rd});
         check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_bready", bready, 0);
      check("rst_rready", rready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_resp", rsp_resp, 0);
      check("rst_rsp_write", rsp_write, 0);
      check("prot", {awprot, arprot}, 0);
      reset = 1'b0;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);

      // Zero-wait write of 12 to the load register
      issue(1'b1, 32'h4, 32'h0000_000C, 4'hF, 32'h0, 2'b00);
      check("wr_awvalid_t1", awvalid, 1);
      check("wr_wvalid_t1", wvalid, 1);
      check("wr_awaddr", awaddr, 32'h4);
      check("wr_wdata", wdata, 32'hC);
      check("wr_wstrb", wstrb, 4'hF);
      check("wr_arvalid", arvalid, 0);
      @(posedge clk); #1;
      check("wr_bready_t2", bready, 1);
      check("wr_awvalid_t2", awvalid, 0);
      get_rsp(20, lat);
      check("wr_rsp_latency", lat, 1);
      check("timer_load", mem[1], 32'hC);

      // Read back, with rsp_ready held off to confirm the response is stable
      rsp_ready = 1'b0;
      issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0000_000C, 2'b00);
      check("rd_arvalid_t1", arvalid, 1);
      check("rd_araddr", araddr, 32'h4);
      check("rd_awvalid", awvalid, 0);
      @(posedge clk); #1;
      check("rd_rready_t2", rready, 1);
      get_rsp(20, lat);
      check("rd_rsp_latency", lat, 1);
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_rdata", rsp_rdata, 32'hC);
      check("rsp_hold_cmd_ready", cmd_ready, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rsp_released", rsp_valid, 0);

      // awready delayed three cycles, wready immediate
      aw_delay = 3;
      issue(1'b1, 32'h8, 32'hA5A5_1234, 4'hC, 32'h0, 2'b00);
      for (int i = 1; i <= 4; i++) begin
         check("dly_awvalid", awvalid, 1);
         check("dly_awaddr", awaddr, 32'h8);
         check("dly_wvalid", wvalid, (i == 1) ? 1 : 0);
         check("dly_bready_low", bready, 0);
         @(posedge clk); #1;
      end
      check("dly_awvalid_drop", awvalid, 0);
      check("dly_bready", bready, 1);
      get_rsp(20, lat);
      check("dly_strobed_write", mem[2], 32'hA5A5_0000);
      aw_delay = 0;

      // Unmapped read returns SLVERR, then a normal read follows
      issue(1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 2'b10);
      get_rsp(20, lat);
      issue(1'b0, 32'h8, 32'h0, 4'h0, 32'hA5A5_0000, 2'b00);
      get_rsp(20, lat);

      // Stalled B channel trips the watchdog without aborting
      b_delay = 20;
      issue(1'b1, 32'hC, 32'h0000_0055, 4'hF, 32'h0, 2'b00);
      repeat (7) @(posedge clk);
      #1;
      check("to_before_8", timeout, 0);
      @(posedge clk); #1;
      check("to_at_8", timeout, 1);
      check("to_bready_held", bready, 1);
      get_rsp(40, lat);
      check("to_sticky", timeout, 1);
      b_delay = 0;
      issue(1'b0, 32'hC, 32'h0, 4'h0, 32'h0000_0055, 2'b00);
      check("to_cleared", timeout, 0);
      get_rsp(20, lat);

      // Reset while waiting in RD_RESP
      r_delay = 50;
      issue(1'b0, 32'h4, 32'h0, 4'h0, 32'hC, 2'b00);
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      check("mid_rready", rready, 1);
      check("mid_timeout", timeout, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_rready", rready, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_timeout", timeout, 0);
      check("mid_rst_arvalid", arvalid, 0);
      reset = 1'b0;
      sb.delete();
      r_delay = 0;
      #1;
      check("post_rst_cmd_ready", cmd_ready, 1);

      // Recovery: byte-lane write then read back
      issue(1'b1, 32'h4, 32'hFFFF_0033, 4'h3, 32'h0, 2'b00);
      get_rsp(20, lat);
      issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0000_0033, 2'b00);
      get_rsp(20, lat);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
